fifo_wr_ctrl: RTL

Write-side controller of the UART asynchronous FIFO, in the `wclk` domain. It owns the write pointer and drives `waddr` and `wfull` into the FIFO storage array. It synchronises the Gray-coded read pointer arriving from the read clock domain and generates full, almost-full, fill-level and overflow status. It also exports its own Gray-coded write pointer to the read-side controller.

---
 rtl/fifo_wr_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - write-side pointer, synchroniser and status for the UART async FIFO
module fifo_wr_ctrl #(
  parameter int A  = 3,
  parameter int AF = 1
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic         i_winc,
  input  logic [A:0]   i_rptr_gray,
  output logic [A-1:0] o_waddr,
  output logic [A:0]   o_wptr_gray,
  output logic         o_wfull,
  output logic         o_walmost_full,
  output logic [A:0]   o_wlevel,
  output logic         o_woverflow
);

  localparam int         D      = 1 << A;
  localparam logic [A:0] LVL_D  = (A+1)'(D);
  localparam logic [A:0] LVL_AF = (A+1)'(D - AF);

  // Parameter sanity: full detection needs two MSBs, margin must leave room
  if (A < 2) begin : g_bad_a
    $error("fifo_wr_ctrl: A must be >= 2");
  end
  if (AF < 1 || AF > D - 1) begin : g_bad_af
    $error("fifo_wr_ctrl: AF must be in 1..D-1");
  end

  logic [A:0] r_wbin;
  logic [A:0] r_wptr_gray;
  logic [A:0] r_rq1;
  logic [A:0] r_rq2;
  logic       r_wfull;
  logic       r_walmost_full;
  logic [A:0] r_wlevel;
  logic       r_woverflow;

  logic       w_wen;
  logic [A:0] w_wbin_next;
  logic [A:0] w_wgray_next;
  logic [A:0] w_full_ptr;
  logic [A:0] w_rbin_s;
  logic [A:0] w_wlevel_next;
  logic       w_wfull_next;
  logic       w_walmost_full_next;
  logic       w_woverflow_next;

  // A write is taken only when the registered full flag says there is room
  assign w_wen        = i_winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + {{A{1'b0}}, w_wen};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal
  assign w_full_ptr   = {~r_rq2[A:A-1], r_rq2[A-2:0]};
  assign w_wfull_next = (w_wgray_next == w_full_ptr);

  // Convert the synchronised Gray read pointer to binary with an MSB-first XOR prefix
  always_comb begin
    w_rbin_s    = '0;
    w_rbin_s[A] = r_rq2[A];
    for (int i = A - 1; i >= 0; i--) begin
      w_rbin_s[i] = w_rbin_s[i+1] ^ r_rq2[i];
    end
  end

  // Level wraps naturally modulo 2^(A+1); a full FIFO reads exactly D
  assign w_wlevel_next       = w_wbin_next - w_rbin_s;
  assign w_walmost_full_next = (w_wlevel_next >= LVL_AF);
  assign w_woverflow_next    = i_winc & r_wfull;

  // Two-flop synchroniser for the read pointer, nothing between the stages
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_rq1 <= '0;
      r_rq2 <= '0;
    end else begin
      r_rq1 <= i_rptr_gray;
      r_rq2 <= r_rq1;
    end
  end

  // Write pointer in binary and Gray; both hold on a rejected write
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin      <= '0;
      r_wptr_gray <= '0;
    end else begin
      r_wbin      <= w_wbin_next;
      r_wptr_gray <= w_wgray_next;
    end
  end

  // Status flags, all computed from the next write pointer and the current synchronised read pointer
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wfull        <= w_wfull_next;
      r_walmost_full <= w_walmost_full_next;
      r_wlevel       <= w_wlevel_next;
      r_woverflow    <= w_woverflow_next;
    end
  end

  assign o_waddr        = r_wbin[A-1:0];
  assign o_wptr_gray    = r_wptr_gray;
  assign o_wfull        = r_wfull;
  assign o_walmost_full = r_walmost_full;
  assign o_wlevel       = r_wlevel;
  assign o_woverflow    = r_woverflow;

  // The Gray full compare and the binary level must always tell the same story
  a_full_matches_level: assert property (@(posedge wclk) disable iff (!wrst_n)
    r_wfull == (r_wlevel == LVL_D));

  // The exported Gray pointer never moves by more than one bit per cycle
  a_gray_one_bit: assert property (@(posedge wclk) disable iff (!wrst_n)
    $countones(r_wptr_gray ^ $past(r_wptr_gray)) <= 1);

endmodule
